// File: rtl/sram_burst_mem.sv
// Single-port synchronous SRAM with burst request, write-data and read-data channels.
// Bursts increment and wrap at DEPTH; reads start RD_WAIT idle cycles after accept.
module sram_burst_mem #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 9,
  parameter int LEN_W   = 4,
  parameter int RD_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  output logic                  wr_done,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic [1:0]            state_dbg
);
  // Every channel transfers on a clock edge where valid && ready are both high;
  // a valid beat holds its payload stable until it is accepted.
  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT_S, READ} state_t;

  localparam int BE_W   = DATA_W / 8;
  localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] acc_addr;
  logic [LEN_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;

  function automatic logic [ADDR_W-1:0] inc_addr(input logic [ADDR_W-1:0] a);
    return (32'(a) == DEPTH - 1) ? '0 : a + ADDR_W'(1);
  endfunction

  assign acc_addr  = ADDR_W'(32'(req_addr) % DEPTH);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      wr_ready  <= 1'b0;
      wr_done   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
      addr      <= '0;
      count     <= '0;
      wait_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr      <= acc_addr;
            count     <= req_len;
            wait_cnt  <= '0;
            if (req_we) begin
              state    <= WRITE;
              wr_ready <= 1'b1;
            end else if (RD_WAIT == 0) begin
              state    <= READ;
              rd_data  <= mem[acc_addr];
              rd_valid <= 1'b1;
              rd_last  <= (req_len == '0);
            end else begin
              state <= RD_WAIT_S;
            end
          end
        end
        WRITE: begin
          if (wr_valid) begin
            for (int b = 0; b < BE_W; b++)
              if (wr_be[b]) mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
            addr  <= inc_addr(addr);
            count <= count - LEN_W'(1);
            if (count == '0) begin
              state    <= IDLE;
              wr_ready <= 1'b0;
              wr_done  <= 1'b1;
            end
          end
        end
        RD_WAIT_S: begin
          if (wait_cnt == WAIT_LAST) begin
            state    <= READ;
            rd_data  <= mem[addr];
            rd_valid <= 1'b1;
            rd_last  <= (count == '0);
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        READ: begin
          if (rd_ready) begin
            if (rd_last) begin
              state    <= IDLE;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end else begin
              // Next word is fetched on the handshake edge so beats stream at 1/clk.
              addr    <= inc_addr(addr);
              rd_data <= mem[inc_addr(addr)];
              count   <= count - LEN_W'(1);
              rd_last <= (count == LEN_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_burst_mem.sv
// Self-checking bench for sram_burst_mem: directed scenarios plus random bursts
// compared against a plain array model of the memory.
module tb_sram_burst_mem;
  localparam int DATA_W  = 64;
  localparam int DEPTH   = 512;
  localparam int ADDR_W  = 9;
  localparam int LEN_W   = 4;
  localparam int RD_WAIT = 2;
  localparam int BE_W    = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic [BE_W-1:0]   wr_be = '0;
  logic              wr_done;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic [1:0]        state_dbg;

  sram_burst_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                   .LEN_W(LEN_W), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
    .wr_done(wr_done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] wdat [16];
  logic [BE_W-1:0]   wbe  [16];

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  // Called 1 time unit after an edge; asserts rst mid-cycle.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_busy", DATA_W'(busy), '0);
    check("rst_rd_valid", DATA_W'(rd_valid), '0);
    check("rst_req_ready", DATA_W'(req_ready), '0);
    check("rst_wr_ready", DATA_W'(wr_ready), '0);
    check("rst_rd_data", rd_data, '0);
    req_valid = 1'b0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("rel_req_ready_pre", DATA_W'(req_ready), '0);
    tick();
    check("rel_req_ready", DATA_W'(req_ready), DATA_W'(1));
    check("rel_busy", DATA_W'(busy), '0);
  endtask

  task automatic send_req(input logic we, input int addr, input int len);
    int t = 0;
    while (!req_ready && t < 100) begin
      tick();
      t++;
    end
    check("req_ready_wait", DATA_W'(req_ready), DATA_W'(1));
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = ADDR_W'(addr);
    req_len   = LEN_W'(len);
    tick();
    req_valid = 1'b0;
    req_addr  = ADDR_W'($urandom);
    check("acc_busy", DATA_W'(busy), DATA_W'(1));
    check("acc_req_ready", DATA_W'(req_ready), '0);
  endtask

  task automatic do_write(input int addr, input int len);
    send_req(1'b1, addr, len);
    for (int i = 0; i <= len; i++) begin
      int a = (addr + i) % DEPTH;
      if ($urandom_range(0, 3) == 0) begin
        // Junk on the data bus while wr_valid is low must not be written.
        wr_valid = 1'b0;
        wr_data  = {$urandom, $urandom};
        wr_be    = '1;
        tick();
      end
      check("wr_ready", DATA_W'(wr_ready), DATA_W'(1));
      wr_valid = 1'b1;
      wr_data  = wdat[i];
      wr_be    = wbe[i];
      tick();
      for (int b = 0; b < BE_W; b++)
        if (wbe[i][b]) model_mem[a][8*b +: 8] = wdat[i][8*b +: 8];
      check("wr_done", DATA_W'(wr_done), DATA_W'(i == len));
    end
    wr_valid = 1'b0;
    check("wr_end_busy", DATA_W'(busy), '0);
    check("wr_end_req_ready", DATA_W'(req_ready), '0);
    check("wr_end_wr_ready", DATA_W'(wr_ready), '0);
    tick();
    check("wr_done_drop", DATA_W'(wr_done), '0);
  endtask

  // stall0 > 0: stall beat 0 that many cycles; stall0 < 0: random stalls.
  // abort_at >= 0: assert reset just before that beat is consumed.
  task automatic do_read(input int addr, input int len, input int stall0, input int abort_at);
    int lat;
    logic [DATA_W-1:0] hold_d;
    logic hold_l;
    send_req(1'b0, addr, len);
    for (int i = 0; i <= len; i++) exp_q.push_back(model_mem[(addr + i) % DEPTH]);
    lat = 1;
    while (!rd_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("rd_latency", DATA_W'(lat), DATA_W'(RD_WAIT + 1));
    for (int i = 0; i <= len; i++) begin
      int stall;
      if (i == abort_at) begin
        do_reset();
        return;
      end
      stall  = (stall0 > 0 && i == 0) ? stall0 : (stall0 < 0 ? int'($urandom_range(0, 2)) : 0);
      hold_d = rd_data;
      hold_l = rd_last;
      for (int s = 0; s < stall; s++) begin
        rd_ready = 1'b0;
        tick();
        check("bp_valid", DATA_W'(rd_valid), DATA_W'(1));
        check("bp_data", rd_data, hold_d);
        check("bp_last", DATA_W'(rd_last), DATA_W'(hold_l));
      end
      check("rd_valid", DATA_W'(rd_valid), DATA_W'(1));
      check("rd_data", rd_data, exp_q.pop_front());
      check("rd_last", DATA_W'(rd_last), DATA_W'(i == len));
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    check("rd_end_valid", DATA_W'(rd_valid), '0);
    check("rd_end_busy", DATA_W'(busy), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    #1;
    check("init_req_ready", DATA_W'(req_ready), '0);
    check("init_busy", DATA_W'(busy), '0);
    check("init_rd_valid", DATA_W'(rd_valid), '0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("init_rel_req_ready", DATA_W'(req_ready), DATA_W'(1));

    // 1: async reset while idle, then read of cleared memory
    do_reset();
    do_read(5, 0, 0, -1);

    // 2: four-beat write then streaming read
    for (int i = 0; i < 4; i++) begin
      wdat[i] = {16{4'(i + 1)}};
      wbe[i]  = '1;
    end
    do_write(10, 3);
    do_read(10, 3, 0, -1);

    // 3: partial byte enables
    wdat[0] = '1; wbe[0] = '1;
    do_write(20, 0);
    wdat[0] = '0; wbe[0] = 8'h0F;
    do_write(20, 0);
    do_read(20, 0, 0, -1);

    // 4: burst wrapping past the top word
    wdat[0] = {16{4'hA}}; wdat[1] = {16{4'hB}}; wdat[2] = {16{4'hC}};
    wbe[0] = '1; wbe[1] = '1; wbe[2] = '1;
    do_write(511, 2);
    do_read(511, 2, 0, -1);
    do_read(0, 1, 0, -1);

    // 5: back-pressure on the first beat
    do_read(10, 1, 4, -1);

    // 6: reset in the middle of a long read, then memory must read as zero
    do_read(8, 7, 0, 2);
    do_read(8, 7, 0, -1);

    // random bursts
    for (int n = 0; n < 30; n++) begin
      int len  = $urandom_range(0, 15);
      int addr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(500, 511))
                                             : int'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wdat[i] = {$urandom, $urandom};
          wbe[i]  = BE_W'($urandom_range(0, 255));
        end
        do_write(addr, len);
      end else begin
        do_read(addr, len, -1, -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/sram_burst_mem.md
Name: sram_burst_mem

Overview:
- Parametrised single-port synchronous SRAM model with a valid/ready request channel, a separate write-data channel and a separate read-data channel. There is no inout bus.
- Supports incrementing bursts of 1..2^LEN_W beats, per-byte write enables, a configurable read access wait and read back-pressure.
- Sits between the memory-stage/cache controller and backing storage. It is the next-generation replacement for the fixed 64-bit inout SRAM model.

Parameters:
- DATA_W, 64, word width in bits; must be a multiple of 8.
- DEPTH, 512, number of words.
- ADDR_W, 9, word-address width; DEPTH <= 2^ADDR_W.
- LEN_W, 4, burst-length field width; the request carries beats-1.
- RD_WAIT, 2, idle cycles between read-request accept and the first read beat; 0 is legal.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_we  in  1  1=write burst, 0=read burst
- req_addr  in  ADDR_W  start word address
- req_len  in  LEN_W  beats-1
- wr_valid  in  1  write beat valid
- wr_ready  out  1  write beat accepted when valid&&ready
- wr_data  in  DATA_W  write beat data
- wr_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i]
- wr_done  out  1  one-cycle pulse after the last write beat commits
- rd_valid  out  1  read beat valid
- rd_ready  in  1  consumer accepts beat
- rd_data  out  DATA_W  read beat data
- rd_last  out  1  marks the final beat of a read burst
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - req_ready=0 while rst is high, then 1 from the first clk edge after release.
  - wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, wr_done=0, busy=0.
  - All memory words are cleared to 0.
  - Reset mid-burst abandons the burst. Writes already committed stay committed until the clear; no further beats are produced.
- FSM states: IDLE, WRITE, RD_WAIT_S, READ.
  - IDLE: req_ready=1. On req_valid, latch addr and count=req_len.
    - Write request: go to WRITE.
    - Read request with RD_WAIT>0: go to RD_WAIT_S.
    - Read request with RD_WAIT=0: go directly to READ with beat 0 loaded.
  - WRITE: wr_ready=1. Each accepted beat updates mem[addr] for bytes with be=1 only; bytes with be=0 are untouched. Address increments after each beat.
    - When the beat with count==0 is accepted, go to IDLE and pulse wr_done on the following cycle.
  - RD_WAIT_S: a counter runs RD_WAIT cycles. On its last cycle, load rd_data=mem[addr], rd_valid=1 and rd_last=(count==0), then enter READ.
  - READ: rd_data, rd_valid and rd_last hold stable while rd_valid && !rd_ready.
    - On a handshake with count>0: in the same edge, load the next word, decrement count and increment address. Back-to-back beats run at 1 beat/clk.
    - On a handshake with rd_last=1: rd_valid drops to 0 and the FSM goes to IDLE.
- Latency:
  - First read beat valid RD_WAIT+1 edges after request accept.
  - A write beat is visible to a read request accepted on the next cycle.
- Address arithmetic: addr_next = (addr+1 == DEPTH) ? 0 : addr+1, so bursts wrap at DEPTH. A request with req_addr >= DEPTH is reduced modulo DEPTH at accept.
- Only one burst is outstanding at a time. req_ready=0 in every non-IDLE state, including the cycle the last beat completes.
- wr_valid is ignored outside WRITE. rd_ready is ignored when rd_valid=0.
- A request accepted on the same edge that a burst ends is impossible, because req_ready=0 on that cycle. The next request is accepted no earlier than the following cycle.

Test Plan:
1. Reset then idle: assert rst mid-cycle (async) -> busy=0, rd_valid=0 and req_ready=0 immediately; req_ready=1 after the first edge post-release; a read of addr 5, len 0 returns 0.
2. Write burst addr 10, len 3, data 0x1111..1 through 0x4444..4, all be=FF -> wr_done pulses once one cycle after the 4th beat. A read of addr 10, len 3 with rd_ready=1 returns the 4 words on consecutive cycles, with rd_last only on the 4th and the first beat RD_WAIT+1=3 edges after accept.
3. Byte enables: write 0xFFFF_FFFF_FFFF_FFFF to addr 20, then write 0x0 with be=0x0F -> a read of addr 20 returns 0xFFFF_FFFF_0000_0000.
4. Wrap: write len 2 at addr 511 with data A, B, C -> mem[511]=A, mem[0]=B, mem[1]=C; a read at addr 511, len 2 returns A, B, C.
5. Back-pressure: read len 1 with rd_ready held low 4 cycles on beat 0 -> rd_data and rd_valid stay stable throughout; beat 1 appears on the edge after rd_ready rises.
6. Reset mid-read burst (len 7, after 2 beats) -> rd_valid=0 asynchronously; after release busy=0 and a fresh read returns all-zero data.
